// File: rtl/first_counter_pkg.sv
// Shared constants and helpers for first_counter.
package first_counter_pkg;

   localparam int FIRST_COUNTER_WIDTH = 4;

   // Largest count representable in `width` bits (2^width - 1).
   function automatic logic [63:0] max_count(input int width);
      return (64'd1 << width) - 64'd1;
   endfunction

endpackage

// File: rtl/first_counter.sv
// Enabled up-counter with a one-cycle terminal-count pulse.
// Define FIRST_COUNTER_SAT_EN to saturate at the maximum count instead of wrapping.
module first_counter
   import first_counter_pkg::*;
#(
   parameter int               WIDTH       = FIRST_COUNTER_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   output logic [WIDTH-1:0] counter_out,
   output logic             tc_pulse
);

   localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(max_count(WIDTH));

   logic [WIDTH-1:0] r_count;
   logic             r_tc;

`ifdef FIRST_COUNTER_SAT_EN
   logic [WIDTH-1:0] w_next;

   assign w_next = r_count + WIDTH'(1);

   // Once at MAX_COUNT the counter is parked; only reset releases it.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_count <= RESET_VALUE;
         r_tc    <= 1'b0;
      end else if (enable && (r_count != MAX_COUNT)) begin
         r_count <= w_next;
         r_tc    <= (w_next == MAX_COUNT);
      end else begin
         r_tc    <= 1'b0;
      end
   end
`else
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_next;
   logic             w_carry;

   // The carry out of the WIDTH-bit increment is exactly the wrap event.
   assign w_sum   = {1'b0, r_count} + {{WIDTH{1'b0}}, 1'b1};
   assign w_next  = w_sum[WIDTH-1:0];
   assign w_carry = w_sum[WIDTH];

   always_ff @(posedge clock) begin
      if (reset) begin
         r_count <= RESET_VALUE;
         r_tc    <= 1'b0;
      end else if (enable) begin
         r_count <= w_next;
         r_tc    <= w_carry;
      end else begin
         r_tc    <= 1'b0;
      end
   end
`endif

   assign counter_out = r_count;
   assign tc_pulse    = r_tc;

endmodule

// File: tb/tb_first_counter.sv
// Scoreboard bench for first_counter: driver pushes model results, monitor pops and compares.
// Follows FIRST_COUNTER_SAT_EN the same way the design does.
module tb_first_counter;

   localparam int W    = 4;
   localparam int MAXC = (1 << W) - 1;

   logic         clock = 1'b1;
   logic         reset = 1'b0;
   logic         enable = 1'b0;
   logic [W-1:0] counter_out;
   logic         tc_pulse;

   int checks = 0;
   int errors = 0;

   // Expected {tc_pulse, counter_out} after each rising edge.
   logic [W:0] exp_q[$];

   int m_count = 0;
   bit m_tc    = 1'b0;

   first_counter dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .counter_out (counter_out),
      .tc_pulse    (tc_pulse)
   );

   always #5 clock = ~clock;

   // Reference model: counts edges with enable, from the behavioural rules.
   task automatic model_edge(input bit r, input bit e);
      if (r) begin
         m_count = 0;
         m_tc    = 1'b0;
      end else if (e) begin
`ifdef FIRST_COUNTER_SAT_EN
         if (m_count == MAXC) begin
            m_tc = 1'b0;
         end else begin
            m_count = m_count + 1;
            m_tc    = (m_count == MAXC);
         end
`else
         m_tc    = (m_count == MAXC);
         m_count = (m_count + 1) % (MAXC + 1);
`endif
      end else begin
         m_tc = 1'b0;
      end
   endtask

   // Drive inputs on the falling edge and queue the result of the next rising edge.
   task automatic step(input bit r, input bit e);
      logic [W:0] exp_v;
      reset  = r;
      enable = e;
      model_edge(r, e);
      exp_v  = {m_tc, W'(m_count)};
      exp_q.push_back(exp_v);
      @(negedge clock);
   endtask

   always @(posedge clock) begin
      logic [W:0] exp_v;
      #1;
      if (exp_q.size() > 0) begin
         exp_v  = exp_q.pop_front();
         checks = checks + 1;
         if ({tc_pulse, counter_out} !== exp_v) begin
            errors = errors + 1;
            $display("FAIL count_tc @%0t: got tc=%b count=%0d, expected tc=%b count=%0d",
                     $time, tc_pulse, counter_out, exp_v[W], exp_v[W-1:0]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      @(negedge clock);                         // t=5
      step(1'b1, 1'b0);                         // reset over edge t=10
      step(1'b0, 1'b0);                         // hold over edge t=20
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1);  // count to 10
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);   // hold at 10

      step(1'b1, 1'b0);                         // wrap run from 0
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1);
      step(1'b0, 1'b0);

      step(1'b1, 1'b0);                         // reset priority at count 7
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);

      step(1'b1, 1'b0);                         // long run: saturation or repeated wraps
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1);

      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0));
      end

      repeat (2) @(negedge clock);
      checks = checks + 1;
      if (exp_q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL drain: got %0d pending results, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
